locked_rr_switch_arbiter: RTL

- Shares one downstream flit channel among N upstream requesters.
- Packet-level round-robin: a winner keeps the output until the handshake of its `last` flit, so multi-flit packets are never interleaved.
- A QUANTUM counter lets one input send up to QUANTUM back-to-back packets before priority rotates.
- Sits at each switch output port in front of the output buffer; also drives the datapath mux select.

---
 rtl/axi4_duth_noc_pkg.sv | 10 +
 rtl/locked_rr_switch_arbiter_rr_pick.sv | 32 +++
 rtl/locked_rr_switch_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/axi4_duth_noc_pkg.sv
// Shared types and helpers for the NoC switch arbitration blocks.
package axi4_duth_noc_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_lock_state_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/locked_rr_switch_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning cyclically from ptr.
module rr_pick
  import axi4_duth_noc_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && reqs[pos[IW-1:0]]) begin
        found                = 1'b1;
        grant[pos[IW-1:0]]   = 1'b1;
        index                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/locked_rr_switch_arbiter.sv
// Packet-locked round-robin arbiter for one switch output port; owner_oh doubles as the
// datapath mux select.
module locked_rr_switch_arbiter
  import axi4_duth_noc_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int PRI_RST = 0,
  parameter int QUANTUM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_valid,
  input  logic [N-1:0]  in_last,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [N-1:0]  owner_oh,
  output logic          busy
);

  localparam int IW = idx_w(N);
  localparam int CW = $clog2(QUANTUM + 1);

  arb_lock_state_t state, state_next;
  logic [IW-1:0]   owner, owner_next, ptr, ptr_next, g, pick_idx;
  logic [CW-1:0]   pkt_cnt, cnt_next, cnt_inc;
  logic [N-1:0]    pick_oh;
  logic            hs, hs_last;

  rr_pick #(.N(N)) u_pick (
    .reqs  (in_valid),
    .ptr   (ptr),
    .grant (pick_oh),
    .index (pick_idx)
  );

  assign g       = (state == ARB_LOCKED) ? owner : pick_idx;
  assign hs      = out_valid & out_ready;
  assign hs_last = hs & out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (hs_last) state_next = ARB_IDLE;
    else if (hs) state_next = ARB_LOCKED;
  end

  // Outputs are forced low while reset is asserted, even though IDLE would otherwise
  // forward a live request straight through.
  always_comb begin
    owner_oh = '0;
    if (rst) owner_oh = (state == ARB_LOCKED) ? (N'(1) << owner) : pick_oh;
    out_valid = |(in_valid & owner_oh);
    out_last  = |(in_last & owner_oh);
    in_ready  = owner_oh & {N{out_ready}};
    busy      = rst && (state == ARB_LOCKED);
    out_data  = '0;
    for (int i = 0; i < N; i++)
      out_data = out_data | (in_data[i*DW +: DW] & {DW{owner_oh[i]}});
  end

  // A nonzero pkt_cnt only survives a packet end that left ptr on its owner, so the
  // previous packet's owner is ptr whenever the count matters.
  always_comb begin
    owner_next = owner;
    ptr_next   = ptr;
    cnt_next   = pkt_cnt;
    cnt_inc    = (g == ptr) ? pkt_cnt + 1'b1 : CW'(1);
    if (hs) owner_next = g;
    if (hs_last) begin
      if (cnt_inc == CW'(QUANTUM)) begin
        ptr_next = (g == IW'(N-1)) ? '0 : g + 1'b1;
        cnt_next = '0;
      end else begin
        ptr_next = g;
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= '0;
      ptr     <= IW'(PRI_RST);
      pkt_cnt <= '0;
    end else begin
      owner   <= owner_next;
      ptr     <= ptr_next;
      pkt_cnt <= cnt_next;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(owner_oh));
  a_lock:   assert property (@(posedge clk) disable iff (!rst)
                             (busy && !hs_last) |=> (owner_oh == $past(owner_oh)));

endmodule
